matrix_stream_loader: RTL and testbench

Write-side companion of the vertex transform engine. Accepts the 16 signed fixed-point coefficients of a 4x4 transform matrix as a serial valid/ready word stream (from the PS-side DMA), assembles them in a shadow buffer, and commits them atomically to the parallel `transform_matrix` bus the engine reads. Commits happen only while the engine is idle, so a matrix never changes mid-frame.

---
 rtl/matrix_stream_loader.sv | 130 +++++++++++++
 tb/tb_matrix_stream_loader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_stream_loader.sv
// Serial valid/ready loader for a 4x4 fixed-point transform matrix: words are assembled in a
// shadow buffer and committed atomically to the active bus only while the engine is idle.
module matrix_stream_loader #(
    parameter int unsigned M = 11,
    parameter int unsigned N = 7,
    parameter int unsigned W = M + N
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    s_data,
    input  logic            s_valid,
    input  logic            s_last,
    output logic            s_ready,
    input  logic            engine_busy,
    input  logic            clr_err,
    output logic [16*W-1:0] matrix_out,
    output logic            matrix_valid,
    output logic            swap_pulse,
    output logic            err_len
);

    typedef enum logic [1:0] {StLoad, StDrain, StPending} state_e;

    localparam logic [W-1:0] CoefOne = {{(W-1){1'b0}}, 1'b1} << N;

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [15:0][W-1:0]   shadow_q;
    logic [15:0][W-1:0]   active_q;
    logic                 accept;
    logic                 shadow_we;
    logic                 commit;
    logic                 err_set;

    assign s_ready    = (state_q != StPending);
    assign accept     = s_valid & s_ready;
    assign matrix_out = active_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shadow_we = 1'b0;
        commit    = 1'b0;
        err_set   = 1'b0;
        unique case (state_q)
            StLoad: begin
                if (accept) begin
                    shadow_we = 1'b1;
                    if (cnt_q != 4'd15) begin
                        if (s_last) begin
                            err_set = 1'b1;
                            cnt_d   = 4'd0;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else begin
                        cnt_d = 4'd0;
                        if (s_last) begin
                            state_d = StPending;
                        end else begin
                            err_set = 1'b1;
                            state_d = StDrain;
                        end
                    end
                end
            end
            StDrain: begin
                if (accept && s_last) begin
                    state_d = StLoad;
                end
            end
            StPending: begin
                if (!engine_busy) begin
                    commit  = 1'b1;
                    state_d = StLoad;
                end
            end
            default: begin
                state_d = StLoad;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StLoad;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
        end else if (shadow_we) begin
            shadow_q[cnt_q] <= s_data;
        end
    end

    // Identity on reset: diagonal entries k = 0, 5, 10, 15 hold 1.0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) begin
                active_q[k] <= (k % 5 == 0) ? CoefOne : '0;
            end
            swap_pulse   <= 1'b0;
            matrix_valid <= 1'b0;
        end else begin
            swap_pulse <= commit;
            if (commit) begin
                active_q     <= shadow_q;
                matrix_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_len <= 1'b0;
        end else if (err_set) begin
            err_len <= 1'b1;
        end else if (clr_err) begin
            err_len <= 1'b0;
        end
    end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Scoreboard bench for matrix_stream_loader: complete 16-word packets push an expected matrix,
// a negedge monitor pops on swap_pulse and tracks the active matrix every cycle.
module tb_matrix_stream_loader;

    localparam int M  = 11;
    localparam int N  = 7;
    localparam int W  = M + N;
    localparam int MW = 16 * W;

    logic          clk;
    logic          rst;
    logic [W-1:0]  s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic          engine_busy;
    logic          clr_err;
    logic [MW-1:0] matrix_out;
    logic          matrix_valid;
    logic          swap_pulse;
    logic          err_len;

    matrix_stream_loader #(.M(M), .N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .engine_busy  (engine_busy),
        .clr_err      (clr_err),
        .matrix_out   (matrix_out),
        .matrix_valid (matrix_valid),
        .swap_pulse   (swap_pulse),
        .err_len      (err_len)
    );

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            acc_cyc = 0;
    int            first_acc = 0;
    int            last_acc = 0;
    int            swap_count = 0;
    int            sc;
    bit            rand_busy_en = 0;
    bit            err_exp = 0;
    logic [W-1:0]  pkt [20];
    logic [MW-1:0] exp_q [$];
    logic [MW-1:0] model_active;
    logic          model_mv;
    logic [W-1:0]  e_coef;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [MW-1:0] identity();
        logic [MW-1:0] m;
        m = '0;
        for (int k = 0; k < 16; k += 5) m[k*W +: W] = W'(1 << N);
        return m;
    endfunction

    task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: the active matrix may only change on a swap, and then to the oldest pending packet.
    always @(negedge clk) begin
        if (!rst) begin
            if (swap_pulse) begin
                swap_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_swap: swap_pulse=1 with no committed packet expected");
                end else begin
                    model_active = exp_q.pop_front();
                    model_mv     = 1'b1;
                end
            end
            chk("matrix_out", matrix_out, model_active);
            chk("matrix_valid", MW'(matrix_valid), MW'(model_mv));
        end
    end

    always @(posedge clk) begin
        if (rand_busy_en) begin
            #2;
            engine_busy = ($urandom_range(0, 2) == 0);
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input logic [W-1:0] d, input logic last, input bit gaps);
        int n;
        if (gaps) cycles($urandom_range(0, 2));
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        n = 0;
        while (!s_ready && n < 200) begin
            cycles(1);
            n++;
        end
        if (!s_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: s_ready=0 after %0d cycles, required 1", n);
        end
        cycles(1);
        acc_cyc = cyc;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_packet(input int len, input bit gaps);
        logic [MW-1:0] m;
        for (int i = 0; i < len; i++) begin
            beat(pkt[i], (i == len - 1), gaps);
            if (i == 0) first_acc = acc_cyc;
        end
        last_acc = acc_cyc;
        if (len == 16) begin
            for (int k = 0; k < 16; k++) m[k*W +: W] = pkt[k];
            exp_q.push_back(m);
        end else begin
            err_exp = 1'b1;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 20; i++) pkt[i] = W'($urandom);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        cycles(1);
        clr_err = 1'b0;
        err_exp = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst          = 1'b1;
        s_valid      = 1'b0;
        s_last       = 1'b0;
        exp_q.delete();
        model_active = identity();
        model_mv     = 1'b0;
        err_exp      = 1'b0;
        cycles(2);
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        s_data       = '0;
        s_valid      = 1'b0;
        s_last       = 1'b0;
        engine_busy  = 1'b0;
        clr_err      = 1'b0;
        model_active = identity();
        model_mv     = 1'b0;
        cycles(3);
        rst = 1'b0;

        // Reset state
        chk("rst_matrix", matrix_out, identity());
        chk("rst_diag5", MW'(matrix_out[5*W +: W]), MW'(128));
        chk("rst_valid", MW'(matrix_valid), MW'(1'b0));
        chk("rst_ready", MW'(s_ready), MW'(1'b1));
        chk("rst_err", MW'(err_len), MW'(1'b0));

        // Back-to-back load
        for (int k = 0; k < 16; k++) pkt[k] = W'(k * 3 - 20);
        send_packet(16, 0);
        chk("b2b_ready_pending", MW'(s_ready), MW'(1'b0));
        chk("b2b_swap_early", MW'(swap_pulse), MW'(1'b0));
        cycles(1);
        chk("b2b_swap", MW'(swap_pulse), MW'(1'b1));
        e_coef = W'(-20);
        chk("b2b_coef0", MW'(matrix_out[0 +: W]), MW'(e_coef));
        e_coef = W'(25);
        chk("b2b_coef15", MW'(matrix_out[15*W +: W]), MW'(e_coef));
        chk("b2b_valid", MW'(matrix_valid), MW'(1'b1));
        chk("b2b_ready_back", MW'(s_ready), MW'(1'b1));
        sc = last_acc;
        fill_random();
        send_packet(16, 0);
        chk("b2b_spacing", MW'(first_acc - sc), MW'(2));
        cycles(1);
        chk("b2b_swap2", MW'(swap_pulse), MW'(1'b1));

        // Busy hold
        engine_busy = 1'b1;
        fill_random();
        send_packet(16, 0);
        chk("busy_ready0", MW'(s_ready), MW'(1'b0));
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            chk("busy_ready", MW'(s_ready), MW'(1'b0));
            chk("busy_swap", MW'(swap_pulse), MW'(1'b0));
        end
        engine_busy = 1'b0;
        cycles(1);
        chk("busy_commit", MW'(swap_pulse), MW'(1'b1));
        chk("busy_ready_back", MW'(s_ready), MW'(1'b1));

        // Short packet
        cycles(2);
        sc = swap_count;
        fill_random();
        send_packet(5, 0);
        chk("short_err", MW'(err_len), MW'(1'b1));
        chk("short_ready", MW'(s_ready), MW'(1'b1));
        cycles(5);
        chk("short_noswap", MW'(swap_count), MW'(sc));
        fill_random();
        send_packet(16, 0);
        cycles(3);
        chk("short_then_commit", MW'(swap_count), MW'(sc + 1));
        chk("short_then_q", MW'(exp_q.size()), MW'(0));

        // Long packet
        pulse_clr();
        chk("long_clr0", MW'(err_len), MW'(1'b0));
        sc = swap_count;
        fill_random();
        for (int i = 0; i < 20; i++) begin
            beat(pkt[i], (i == 19), 0);
            if (i == 14) chk("long_err_pre", MW'(err_len), MW'(1'b0));
            if (i == 15) begin
                chk("long_err16", MW'(err_len), MW'(1'b1));
                chk("long_ready16", MW'(s_ready), MW'(1'b1));
            end
        end
        cycles(4);
        chk("long_noswap", MW'(swap_count), MW'(sc));
        chk("long_ready_end", MW'(s_ready), MW'(1'b1));
        chk("long_err_hold", MW'(err_len), MW'(1'b1));
        pulse_clr();
        chk("long_clr", MW'(err_len), MW'(1'b0));

        // Reset mid-load
        fill_random();
        for (int i = 0; i < 8; i++) beat(pkt[i], 1'b0, 0);
        do_reset();
        chk("midrst_matrix", matrix_out, identity());
        chk("midrst_valid", MW'(matrix_valid), MW'(1'b0));
        chk("midrst_ready", MW'(s_ready), MW'(1'b1));
        fill_random();
        send_packet(16, 0);
        cycles(3);
        chk("midrst_q", MW'(exp_q.size()), MW'(0));
        chk("midrst_valid_after", MW'(matrix_valid), MW'(1'b1));

        // Randomised packets with random busy and beat gaps
        pulse_clr();
        rand_busy_en = 1;
        for (int p = 0; p < 30; p++) begin
            fill_random();
            send_packet(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 16, 1);
            chk("rand_err", MW'(err_len), MW'(err_exp));
            if ($urandom_range(0, 4) == 0) begin
                pulse_clr();
                chk("rand_clr", MW'(err_len), MW'(1'b0));
            end
        end
        rand_busy_en = 0;
        cycles(1);
        engine_busy = 1'b0;
        cycles(5);
        chk("rand_drain_q", MW'(exp_q.size()), MW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
